// File: rtl/u_lsu.sv
// Load/store sequencer for the core's data SRAM port: one LD/ST at a time,
// byte-lane strobes and replicated write data out, extended load data back.

module u_lsu_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,
  input  logic [1:0] off,
  input  logic [7:0] b_byte,
  input  logic [7:0] b_half,
  input  logic [7:0] b_word,
  output logic       stb,
  output logic [7:0] wbyte
);
  localparam logic [1:0] LID = 2'(LANE);

  always_comb begin
    stb   = 1'b0;
    wbyte = b_word;
    case (size)
      2'b00: begin
        stb   = (off == LID);
        wbyte = b_byte;
      end
      2'b01: begin
        stb   = (off[1] == LID[1]);
        wbyte = b_half;
      end
      default: stb = 1'b1;
    endcase
  end
endmodule

module u_lsu (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_v,
  input  logic        req_ld,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wd,
  output logic        req_rdy,
  output logic        rsp_v,
  output logic [31:0] rsp_rd,
  output logic        rsp_err,
  output logic [15:0] dat_a,
  output logic [3:0]  dat_we,
  output logic [31:0] dat_wd,
  output logic [3:0]  dat_re,
  input  logic [31:0] dat_rd
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {IDLE, ACC, DATA, RSP} state_t;

  state_t      state, state_n;
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [17:0] addr_q;
  logic [31:0] wd_q;

  logic                              accept, req_err, illegal, misal;
  logic [NUM_LANES-1:0]              stb;
  logic [NUM_LANES-1:0][VEC_W-1:0]   lane_wd;
  logic [7:0]                        ld_byte;
  logic [15:0]                       ld_half;
  logic [31:0]                       ld_data;
  logic                              unused_addr;

  assign unused_addr = ^req_addr[31:18];

  assign req_rdy = (state == IDLE) || (state == RSP);
  assign rsp_v   = (state == RSP);
  assign accept  = req_v && req_rdy;

  // Request is screened on the way in so errors never touch the SRAM.
  assign illegal = req_ld ? ((req_f3 == 3'b011) || (req_f3[2:1] == 2'b11))
                          : (req_f3 >= 3'b011);
  assign misal   = ((req_f3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_f3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_err = illegal || misal;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    u_lsu_lane #(.LANE(i)) u_lane (
      .size   (f3_q[1:0]),
      .off    (addr_q[1:0]),
      .b_byte (wd_q[7:0]),
      .b_half (wd_q[8*(i%2) +: 8]),
      .b_word (wd_q[8*i +: 8]),
      .stb    (stb[i]),
      .wbyte  (lane_wd[i])
    );
  end

  assign dat_a  = addr_q[17:2];
  assign dat_wd = lane_wd;
  assign dat_we = (state == ACC && !ld_q) ? stb : 4'b0000;
  assign dat_re = (state == ACC &&  ld_q) ? stb : 4'b0000;

  always_comb begin
    ld_byte = dat_rd[7:0];
    case (addr_q[1:0])
      2'd1:    ld_byte = dat_rd[15:8];
      2'd2:    ld_byte = dat_rd[23:16];
      2'd3:    ld_byte = dat_rd[31:24];
      default: ld_byte = dat_rd[7:0];
    endcase
    ld_half = addr_q[1] ? dat_rd[31:16] : dat_rd[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dat_rd;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = req_err ? RSP : ACC;
      ACC:     state_n = ld_q ? DATA : RSP;
      DATA:    state_n = RSP;
      RSP:     state_n = accept ? (req_err ? RSP : ACC) : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      ld_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wd_q    <= '0;
      rsp_rd  <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        ld_q    <= req_ld;
        f3_q    <= req_f3;
        addr_q  <= req_addr[17:0];
        wd_q    <= req_wd;
        rsp_err <= req_err;
        rsp_rd  <= '0;
      end else if (state == DATA) begin
        rsp_rd <= ld_data;
      end
    end
  end
endmodule

// File: tb/tb_u_lsu.sv
// Randomized bench for u_lsu: SRAM stand-in plus a cycle-indexed expectation
// model built from byte-level load/store semantics.

module tb_u_lsu;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_v = 1'b0, req_ld = 1'b0;
  logic [2:0]  req_f3 = '0;
  logic [31:0] req_addr = '0, req_wd = '0;
  logic        req_rdy, rsp_v, rsp_err;
  logic [31:0] rsp_rd, dat_wd;
  logic [15:0] dat_a;
  logic [3:0]  dat_we, dat_re;
  logic [31:0] dat_rd = '0;

  always #5 clk = ~clk;

  u_lsu dut (
    .clk(clk), .rstn(rstn), .req_v(req_v), .req_ld(req_ld), .req_f3(req_f3),
    .req_addr(req_addr), .req_wd(req_wd), .req_rdy(req_rdy), .rsp_v(rsp_v),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err), .dat_a(dat_a), .dat_we(dat_we),
    .dat_wd(dat_wd), .dat_re(dat_re), .dat_rd(dat_rd)
  );

  // SRAM stand-in: 1-cycle read latency, byte-strobed writes
  logic [31:0] sram [0:65535];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (dat_we[i]) sram[dat_a][8*i +: 8] <= dat_wd[8*i +: 8];
    if (|dat_re) dat_rd <= sram[dat_a];
  end

  // reference: shadow memory and expectations keyed by cycle number
  bit   [31:0] mmem [0:255];
  bit          busy [int];
  logic [31:0] e_rd [int];
  bit          e_err [int];
  logic [3:0]  e_we [int], e_re [int];
  logic [15:0] e_a [int];
  logic [31:0] e_wd [int];

  int   cyc = 0, total = 0, bad = 0;
  bit   started = 0;
  logic [31:0] last_rd, last_wd;
  logic        last_err;
  logic [3:0]  last_we, last_re;
  logic [15:0] last_a;
  int          last_rsp_cyc = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_req(input int n, input bit ld, input bit [2:0] f3,
                           input bit [31:0] a, input bit [31:0] wd);
    int nb, off, w;
    bit err;
    bit [3:0] stb;
    bit [31:0] v, mask, wdr;
    err = ld ? (f3 == 3 || f3 == 6 || f3 == 7) : (f3 >= 3);
    if (f3[1:0] == 2'd1 && a[0]) err = 1;
    if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) err = 1;
    if (err) begin
      e_rd[n+1] = 0; e_err[n+1] = 1;
      return;
    end
    nb  = 1 << f3[1:0];
    off = int'(a[1:0]);
    w   = int'(a[9:2]);
    stb = 4'(((1 << nb) - 1) << off);
    busy[n+1] = 1;
    e_a[n+1]  = a[17:2];
    if (!ld) begin
      for (int i = 0; i < 4; i++) wdr[8*i +: 8] = wd[8*(i % nb) +: 8];
      for (int i = 0; i < 4; i++) if (stb[i]) mmem[w][8*i +: 8] = wdr[8*i +: 8];
      e_we[n+1] = stb; e_wd[n+1] = wdr;
      e_rd[n+2] = 0; e_err[n+2] = 0;
    end else begin
      v = mmem[w] >> (8*off);
      if (nb < 4) begin
        mask = (32'd1 << (8*nb)) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[8*nb-1]) v = v | ~mask;
      end
      e_re[n+1] = stb;
      busy[n+2] = 1;
      e_rd[n+3] = v; e_err[n+3] = 0;
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (started) begin
      chk("req_rdy", 32'(req_rdy), 32'(!busy.exists(cyc)));
      chk("rsp_v", 32'(rsp_v), 32'(e_rd.exists(cyc)));
      if (e_rd.exists(cyc)) begin
        chk("rsp_rd", rsp_rd, e_rd[cyc]);
        chk("rsp_err", 32'(rsp_err), 32'(e_err[cyc]));
      end
      chk("dat_we", 32'(dat_we), e_we.exists(cyc) ? 32'(e_we[cyc]) : 32'd0);
      chk("dat_re", 32'(dat_re), e_re.exists(cyc) ? 32'(e_re[cyc]) : 32'd0);
      if (e_a.exists(cyc)) chk("dat_a", 32'(dat_a), 32'(e_a[cyc]));
      if (e_wd.exists(cyc)) chk("dat_wd", dat_wd, e_wd[cyc]);
      if (rsp_v) begin
        last_rd <= rsp_rd; last_err <= rsp_err; last_rsp_cyc <= cyc;
      end
      if (|dat_we) begin
        last_we <= dat_we; last_wd <= dat_wd; last_a <= dat_a;
      end
      if (|dat_re) last_re <= dat_re;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input bit ld, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, output int acc);
    int g = 0;
    while (busy.exists(cyc)) begin
      // garbage while busy must be ignored
      req_v = 1; req_ld = 1'($urandom); req_f3 = 3'($urandom);
      req_addr = $urandom; req_wd = $urandom;
      step();
      g++;
      if (g > 20) begin
        total++; bad++;
        $display("FAIL issue_timeout: ready never seen at cyc %0d", cyc);
        break;
      end
    end
    req_v = 1; req_ld = ld; req_f3 = f3; req_addr = a; req_wd = wd;
    acc = cyc;
    model_req(cyc, ld, f3, a, wd);
    step();
    req_v = 0;
  endtask

  int a, s, l;
  bit [2:0] f3r;
  bit [2:0] legal_ld [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    for (int i = 0; i < 256; i++) begin
      mmem[i] = $urandom;
      sram[i] = mmem[i];
    end
    #2;
    chk("rst_rdy", 32'(req_rdy), 32'd1);
    chk("rst_rsp_v", 32'(rsp_v), 32'd0);
    chk("rst_rsp_rd", rsp_rd, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_dat_a", 32'(dat_a), 32'd0);
    chk("rst_dat_we", 32'(dat_we), 32'd0);
    chk("rst_dat_wd", dat_wd, 32'd0);
    chk("rst_dat_re", 32'(dat_re), 32'd0);
    @(posedge clk); #1;
    rstn = 1; started = 1;

    // directed cases with hand-computed values
    issue(0, 3'd2, 32'h104, 32'hDEADBEEF, a); repeat (2) step();
    chk("sw_a", 32'(last_a), 32'h41);
    chk("sw_we", 32'(last_we), 32'hF);
    chk("sw_wd", last_wd, 32'hDEADBEEF);
    chk("sw_lat", last_rsp_cyc, a + 2);
    chk("sw_err", 32'(last_err), 32'd0);
    issue(0, 3'd2, 32'h104, 32'h80FF1234, a); repeat (2) step();
    issue(1, 3'd0, 32'h107, 32'h0, a); repeat (3) step();
    chk("lb_re", 32'(last_re), 32'h8);
    chk("lb_rd", last_rd, 32'hFFFFFF80);
    chk("lb_lat", last_rsp_cyc, a + 3);
    issue(1, 3'd4, 32'h107, 32'h0, a); repeat (3) step();
    chk("lbu_rd", last_rd, 32'h00000080);
    issue(0, 3'd1, 32'h6, 32'h0000ABCD, a); repeat (2) step();
    chk("sh_we", 32'(last_we), 32'hC);
    chk("sh_wd", last_wd, 32'hABCDABCD);
    issue(1, 3'd5, 32'h6, 32'h0, a); repeat (3) step();
    chk("lhu_rd", last_rd, 32'h0000ABCD);
    issue(1, 3'd1, 32'h6, 32'h0, a); repeat (3) step();
    chk("lh_rd", last_rd, 32'hFFFFABCD);
    issue(1, 3'd2, 32'h2, 32'h0, a); step();
    chk("lw_mis_err", 32'(last_err), 32'd1);
    chk("lw_mis_rd", last_rd, 32'd0);
    chk("lw_mis_lat", last_rsp_cyc, a + 1);
    issue(0, 3'd3, 32'h10, 32'h12345678, a); step();
    chk("st_f3_err", 32'(last_err), 32'd1);
    chk("st_f3_lat", last_rsp_cyc, a + 1);

    // back-to-back store then load
    issue(0, 3'd2, 32'h20, 32'h11223344, s);
    issue(1, 3'd2, 32'h20, 32'h0, l);
    chk("b2b_accept", l, s + 2);
    repeat (3) step();
    chk("b2b_rd", last_rd, 32'h11223344);
    chk("b2b_lat", last_rsp_cyc, l + 3);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_v = 0;
        step();
      end
      f3r = ($urandom_range(0, 9) == 0) ? 3'($urandom) : legal_ld[$urandom_range(0, 4)];
      issue(1'($urandom), f3r, ($urandom & 32'hFFFC0000) | $urandom_range(0, 1023),
            $urandom, a);
    end
    repeat (5) step();

    // async reset during the DATA cycle of a load
    issue(1, 3'd2, 32'h100, 32'h0, a); step();
    #2;
    rstn = 0;
    busy.delete(); e_rd.delete(); e_err.delete(); e_we.delete();
    e_re.delete(); e_a.delete(); e_wd.delete();
    #1;
    chk("rst_mid_re", 32'(dat_re), 32'd0);
    chk("rst_mid_rsp_v", 32'(rsp_v), 32'd0);
    chk("rst_mid_rdy", 32'(req_rdy), 32'd1);
    step();
    rstn = 1;
    repeat (2) step();
    issue(0, 3'd2, 32'h0C, 32'hCAFEF00D, a); repeat (2) step();
    chk("post_rst_lat", last_rsp_cyc, a + 2);
    chk("post_rst_err", 32'(last_err), 32'd0);
    chk("post_rst_wd", last_wd, 32'hCAFEF00D);
    issue(1, 3'd2, 32'h0C, 32'h0, a); repeat (3) step();
    chk("post_rst_rd", last_rd, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
